// File: rtl/dsp_mac_seq_ctrl.sv
// dsp_mac_seq_ctrl: sequenced 20x18 signed dot-product MAC with start/done handshake.
// Optional sticky overflow flag and ovf port when DSP_SEQ_OVF_FLAG_EN is defined.
module dsp_mac_seq_ctrl (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          len,
    input  logic                subtract_i,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic signed [19:0]  A,
    input  logic signed [17:0]  B,
    output logic                busy,
    output logic                done,
    output logic signed [37:0]  P
`ifdef DSP_SEQ_OVF_FLAG_EN
    ,
    output logic                ovf
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t             state, state_n;
    logic [7:0]         count;
    logic signed [37:0] acc, acc_n, prod;
    logic               sub, beat, go, last;
`ifdef DSP_SEQ_OVF_FLAG_EN
    logic               flag, ov;
`endif
    always_comb begin
        prod    = {{18{A[19]}}, A} * {{20{B[17]}}, B};
        acc_n   = sub ? acc - prod : acc + prod;
        a_ready = state == RUN;
        busy    = state != IDLE;
        done    = state == DONE;
        beat    = a_valid && a_ready;
        go      = start && state == IDLE;
        last    = beat && count == 8'd1;
        state_n = go ? (len == 8'd0 ? DONE : RUN) :
                  last ? DONE :
                  state == DONE ? IDLE : state;
`ifdef DSP_SEQ_OVF_FLAG_EN
        // add overflows when operand signs match; subtract when they differ
        ov = (acc[37] == (prod[37] ^ sub)) && (acc_n[37] != acc[37]);
`endif
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            P     <= '0;
            count <= '0;
            sub   <= 1'b0;
`ifdef DSP_SEQ_OVF_FLAG_EN
            flag  <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            if (go) begin
                acc   <= '0;
                count <= len;
                sub   <= subtract_i;
`ifdef DSP_SEQ_OVF_FLAG_EN
                flag  <= 1'b0;
                if (len == 8'd0) ovf <= 1'b0;
`endif
                if (len == 8'd0) P <= '0;
            end else if (beat) begin
                acc   <= acc_n;
                count <= count - 8'd1;
`ifdef DSP_SEQ_OVF_FLAG_EN
                flag  <= flag | ov;
                if (last) ovf <= flag | ov;
`endif
                if (last) P <= acc_n;
            end
        end
    end
endmodule

// File: tb/tb_dsp_mac_seq_ctrl.sv
// tb_dsp_mac_seq_ctrl: table-driven jobs plus directed reset, len=0 and abort sequences.
module tb_dsp_mac_seq_ctrl;
    logic               clk = 1'b0, reset = 1'b1, start = 1'b0, subtract_i = 1'b0, a_valid = 1'b0;
    logic [7:0]         len = '0;
    logic signed [19:0] A = '0;
    logic signed [17:0] B = '0;
    logic               a_ready, busy, done;
    logic signed [37:0] P;
`ifdef DSP_SEQ_OVF_FLAG_EN
    logic               ovf;
`endif
    int n_cmp = 0, n_bad = 0;

    dsp_mac_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .subtract_i(subtract_i),
        .a_valid(a_valid), .a_ready(a_ready), .A(A), .B(B),
        .busy(busy), .done(done), .P(P)
`ifdef DSP_SEQ_OVF_FLAG_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int              n;
        logic            sub;
        logic [0:3][19:0] a;
        logic [0:3][17:0] b;
        int              gap;
        longint          p;
        logic            ov;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v);
        @(negedge clk);
        start = 1'b1; len = 8'(v.n); subtract_i = v.sub;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < v.n; k++) begin
            if (k > 0)
                repeat (v.gap) begin
                    chk("gap_busy", longint'(busy), 1);
                    chk("gap_done", longint'(done), 0);
                    @(negedge clk);
                end
            a_valid = 1'b1; A = v.a[k]; B = v.b[k];
            chk("a_ready", longint'(a_ready), 1);
            @(negedge clk);
            a_valid = 1'b0;
            if (k < v.n - 1) chk("early_done", longint'(done), 0);
        end
        chk("done", longint'(done), 1);
        chk("P", longint'(P), v.p);
`ifdef DSP_SEQ_OVF_FLAG_EN
        chk("ovf", longint'(ovf), longint'(v.ov));
`endif
        @(negedge clk);
        chk("done_pulse", longint'(done), 0);
        chk("busy_after", longint'(busy), 0);
        chk("P_hold", longint'(P), v.p);
    endtask

    initial begin
        vecs[0] = '{n:1, sub:0, a:{20'sd5, 20'sd0, 20'sd0, 20'sd0}, b:{18'sd2, 18'sd0, 18'sd0, 18'sd0}, gap:0, p:10, ov:0};
        vecs[1] = '{n:3, sub:1, a:{20'sd5, -20'sd3, 20'sd7, 20'sd0}, b:{18'sd2, 18'sd4, -18'sd1, 18'sd0}, gap:0, p:9, ov:0};
        vecs[2] = '{n:4, sub:0, a:{20'sd1, 20'sd2, 20'sd3, 20'sd4}, b:{18'sd1, 18'sd2, 18'sd3, 18'sd4}, gap:2, p:30, ov:0};
        vecs[3] = '{n:2, sub:0, a:{-20'sd7, 20'sd100, 20'sd0, 20'sd0}, b:{18'sd3, -18'sd2, 18'sd0, 18'sd0}, gap:1, p:-221, ov:0};
        vecs[4] = '{n:2, sub:1, a:{-20'sd7, 20'sd100, 20'sd0, 20'sd0}, b:{18'sd3, -18'sd2, 18'sd0, 18'sd0}, gap:0, p:221, ov:0};
        vecs[5] = '{n:2, sub:0, a:{20'h80000, 20'h80000, 20'sd0, 20'sd0}, b:{18'h20000, 18'h20000, 18'sd0, 18'sd0}, gap:0, p:-64'sd137438953472, ov:1};
        vecs[6] = '{n:1, sub:0, a:{20'sd1, 20'sd0, 20'sd0, 20'sd0}, b:{18'sd1, 18'sd0, 18'sd0, 18'sd0}, gap:0, p:1, ov:0};

        repeat (2) @(negedge clk);
        chk("rst_P", longint'(P), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_a_ready", longint'(a_ready), 0);
`ifdef DSP_SEQ_OVF_FLAG_EN
        chk("rst_ovf", longint'(ovf), 0);
`endif
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run(vecs[i]);

        run(vecs[4]);
        @(negedge clk);
        start = 1'b1; len = 8'd0;
        @(negedge clk);
        chk("len0_done", longint'(done), 1);
        chk("len0_P", longint'(P), 0);
        chk("len0_busy", longint'(busy), 1);
        len = 8'd1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy", longint'(busy), 0);
        chk("ign_done", longint'(done), 0);
        @(negedge clk);
        chk("ign_busy2", longint'(busy), 0);

        run(vecs[0]);
        @(negedge clk);
        start = 1'b1; len = 8'd4; subtract_i = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) begin
            a_valid = 1'b1; A = 20'sd3; B = 18'sd3;
            @(negedge clk);
        end
        a_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_P", longint'(P), 0);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_done", longint'(done), 0);
        chk("abort_a_ready", longint'(a_ready), 0);
        start = 1'b1; len = 8'd1;
        @(negedge clk);
        start = 1'b0;
        chk("post_rst_run", longint'(a_ready), 1);
        a_valid = 1'b1; A = 20'sd1; B = 18'sd1;
        @(negedge clk);
        a_valid = 1'b0;
        chk("post_rst_done", longint'(done), 1);
        chk("post_rst_P", longint'(P), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
